// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO MMIO peripheral: bus widths and the
// register-map word offsets.
package gpio_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] OFF_SW_STATE = 3'd0;
  localparam logic [ADDR_W-1:0] OFF_LED      = 3'd1;
  localparam logic [ADDR_W-1:0] OFF_LED_SET  = 3'd2;
  localparam logic [ADDR_W-1:0] OFF_LED_CLR  = 3'd3;
  localparam logic [ADDR_W-1:0] OFF_EDGE     = 3'd4;
  localparam logic [ADDR_W-1:0] OFF_IRQ_EN   = 3'd5;

  function automatic logic addr_mapped(input logic [ADDR_W-1:0] addr);
    return addr <= OFF_IRQ_EN;
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One switch bit: synchroniser chain, counting debouncer and a one-cycle
// rise pulse that is high in the first cycle of a new debounced 1.
module gpio_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   synced;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
    synced  = sync_q[SYNC_STAGES-1];
    cnt_inc = cnt_q + CNT_W'(1);
    cnt_d   = '0;
    level_d = level_q;
    // Any sample agreeing with the accepted level restarts the count.
    if (synced != level_q) begin
      if (cnt_inc == CNT_TC) begin
        level_d = synced;
      end else begin
        cnt_d = cnt_inc;
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/gpio_mmio_port.sv
// Memory-mapped switch/LED peripheral: debounced switches with sticky
// rise flags and a maskable interrupt, LED set/clear/write registers.
module gpio_mmio_port
  import gpio_pkg::*;
#(
  parameter int SW_W            = 16,
  parameter int LED_W           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  led,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              irq
);

  logic [SW_W-1:0]   sw_state;
  logic [SW_W-1:0]   sw_rise;

  logic [LED_W-1:0]  led_q, led_d;
  logic [SW_W-1:0]   edge_flag_q, edge_flag_d;
  logic [SW_W-1:0]   irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept;
  logic              wr_en;
  logic [LED_W-1:0]  wdata_led;
  logic [SW_W-1:0]   wdata_sw;
  logic [SW_W-1:0]   edge_clr;
  logic [DATA_W-1:0] rd_data;
  logic              unused_wdata;

  for (genvar i = 0; i < SW_W; i++) begin : g_sw
    gpio_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .raw   (sw[i]),
      .level (sw_state[i]),
      .rise  (sw_rise[i])
    );
  end

  assign req_ready    = !rsp_valid_q || rsp_ready;
  assign accept       = req_valid && req_ready;
  assign wr_en        = accept && req_we;
  assign wdata_led    = req_wdata[LED_W-1:0];
  assign wdata_sw     = req_wdata[SW_W-1:0];
  assign unused_wdata = ^req_wdata;

  always_comb begin
    rd_data = '0;
    case (req_addr)
      OFF_SW_STATE: rd_data[SW_W-1:0]  = sw_state;
      OFF_LED:      rd_data[LED_W-1:0] = led_q;
      OFF_EDGE:     rd_data[SW_W-1:0]  = edge_flag_q;
      OFF_IRQ_EN:   rd_data[SW_W-1:0]  = irq_en_q;
      default:      rd_data = '0;
    endcase
  end

  always_comb begin
    led_d    = led_q;
    irq_en_d = irq_en_q;
    edge_clr = '0;
    if (wr_en) begin
      case (req_addr)
        OFF_LED:     led_d    = wdata_led;
        OFF_LED_SET: led_d    = led_q | wdata_led;
        OFF_LED_CLR: led_d    = led_q & ~wdata_led;
        OFF_EDGE:    edge_clr = wdata_sw;
        OFF_IRQ_EN:  irq_en_d = wdata_sw;
        default:     led_d    = led_q;
      endcase
    end
    // A new rise wins over a same-cycle write-one-to-clear.
    edge_flag_d = (edge_flag_q & ~edge_clr) | sw_rise;
    irq_d       = |(edge_flag_q & irq_en_q);
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = req_we ? '0 : rd_data;
      rsp_err_d   = !addr_mapped(req_addr);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q       <= '0;
      edge_flag_q <= '0;
      irq_en_q    <= '0;
      irq_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      led_q       <= led_d;
      edge_flag_q <= edge_flag_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign led       = led_q;
  assign irq       = irq_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_gpio_mmio_port.sv
// Bench for gpio_mmio_port: directed scenarios plus a random phase, all
// checked each cycle against a register-level behavioural model.
module tb_gpio_mmio_port;
  import gpio_pkg::*;

  localparam int SW_W  = 16;
  localparam int LED_W = 16;
  localparam int NS    = 2;
  localparam int ND    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sw;
  logic [15:0] led;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, irq;

  always #5 clk = ~clk;

  gpio_mmio_port #(
    .SW_W(SW_W), .LED_W(LED_W), .SYNC_STAGES(NS), .DEBOUNCE_CYCLES(ND)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .led(led),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .irq(irq)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state (register view of the peripheral)
  logic [15:0] m_level, m_rise, m_edge, m_irq_en, m_led;
  logic        m_irq;
  int          m_run [16];
  logic [15:0] m_pipe [$];
  logic        m_rsp_valid;
  logic [31:0] m_rdata;
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_level = '0; m_rise = '0; m_edge = '0; m_irq_en = '0; m_led = '0;
    m_irq = 1'b0; m_rsp_valid = 1'b0; m_rdata = '0; m_err = 1'b0;
    for (int b = 0; b < 16; b++) m_run[b] = 0;
    m_pipe = {};
    repeat (NS) m_pipe.push_back(16'h0);
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    logic        acc, wr;
    logic [31:0] rd;
    logic [15:0] clr, v, lvl;
    acc = req_valid && (!m_rsp_valid || rsp_ready);
    wr  = acc && req_we;
    case (req_addr)
      3'd0:    rd = {16'h0, m_level};
      3'd1:    rd = {16'h0, m_led};
      3'd4:    rd = {16'h0, m_edge};
      3'd5:    rd = {16'h0, m_irq_en};
      default: rd = 32'h0;
    endcase
    m_irq  = |(m_edge & m_irq_en);
    clr    = (wr && req_addr == 3'd4) ? req_wdata[15:0] : 16'h0;
    m_edge = (m_edge & ~clr) | m_rise;
    if (wr) begin
      case (req_addr)
        3'd1:    m_led = req_wdata[15:0];
        3'd2:    m_led = m_led | req_wdata[15:0];
        3'd3:    m_led = m_led & ~req_wdata[15:0];
        3'd5:    m_irq_en = req_wdata[15:0];
        default: ;
      endcase
    end
    if (acc) begin
      m_rsp_valid = 1'b1;
      m_rdata     = req_we ? 32'h0 : rd;
      m_err       = (req_addr > 3'd5);
    end else if (rsp_ready) begin
      m_rsp_valid = 1'b0;
    end
    // Switch seen by the debouncer is the raw value NS edges earlier.
    m_pipe.push_back(sw);
    v   = m_pipe.pop_front();
    lvl = m_level;
    for (int b = 0; b < 16; b++) begin
      if (v[b] != m_level[b]) begin
        m_run[b]++;
        if (m_run[b] == ND) begin
          lvl[b]   = v[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_rise  = lvl & ~m_level;
    m_level = lvl;
  endtask

  task automatic check_outputs();
    chk("led", 32'(led), 32'(m_led));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
    chk("req_ready", 32'(req_ready), 32'(!m_rsp_valid || rsp_ready));
    if (m_rsp_valid) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic bus(input logic we, input logic [2:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; sw = 16'h0005;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    model_reset();

    // Reset and settle
    #1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    #9;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (8) step();
    bus(1'b0, OFF_SW_STATE, 32'h0);
    chk("settle_sw_state", rsp_rdata, 32'h0000_0005);
    chk("settle_err", 32'(rsp_err), 32'h0);

    // Bounce rejection on sw[0]
    bus(1'b1, OFF_EDGE, 32'hFFFF);
    sw = 16'h0004;
    repeat (8) step();
    sw[0] = 1'b1; step(); sw[0] = 1'b0; step();
    sw[0] = 1'b1; step(); sw[0] = 1'b0; step();
    sw[0] = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = OFF_SW_STATE;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("bounce_sw0", 32'(rsp_rdata[0]), (k >= 7) ? 32'h1 : 32'h0);
    end
    req_valid = 1'b0;
    repeat (3) step();
    bus(1'b0, OFF_EDGE, 32'h0);
    chk("bounce_edge", rsp_rdata, 32'h0000_0001);

    // LED write / set / clear back-to-back
    req_valid = 1'b1; req_we = 1'b1;
    req_addr = OFF_LED;     req_wdata = 32'hFFFF_A5A5; step(); chk("led_write", 32'(led), 32'hA5A5);
    req_addr = OFF_LED_SET; req_wdata = 32'h0000_000F; step(); chk("led_set", 32'(led), 32'hA5AF);
    req_addr = OFF_LED_CLR; req_wdata = 32'h0000_0005; step(); chk("led_clr", 32'(led), 32'hA5AA);
    req_valid = 1'b0;

    // Interrupt and W1C race
    bus(1'b1, OFF_EDGE, 32'hFFFF);
    bus(1'b1, OFF_IRQ_EN, 32'h0001);
    step();
    chk("irq_idle", 32'(irq), 32'h0);
    sw[0] = 1'b0; repeat (8) step();
    sw[0] = 1'b1; repeat (8) step();
    chk("irq_rise", 32'(irq), 32'h1);
    sw[0] = 1'b0; repeat (8) step();
    chk("irq_fall_keeps", 32'(irq), 32'h1);
    sw[0] = 1'b1; repeat (6) step();
    bus(1'b1, OFF_EDGE, 32'h0001);
    bus(1'b0, OFF_EDGE, 32'h0);
    chk("race_edge", rsp_rdata, 32'h0000_0001);
    chk("race_irq", 32'(irq), 32'h1);
    bus(1'b1, OFF_EDGE, 32'h0001);
    chk("w1c_irq_lag", 32'(irq), 32'h1);
    step();
    chk("w1c_irq_drop", 32'(irq), 32'h0);

    // Backpressure on an unmapped read
    rsp_ready = 1'b0;
    bus(1'b0, 3'd7, 32'h0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = OFF_LED; req_wdata = 32'h1234;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rdata", rsp_rdata, 32'h0);
      chk("bp_err", 32'(rsp_err), 32'h1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(req_ready), 32'h1);
    step();
    chk("bp_done", 32'(rsp_valid), 32'h0);

    // Random phase
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        int idx;
        idx = int'($urandom_range(0, 15));
        sw[idx] = ~sw[idx];
      end
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 3'($urandom_range(0, 7));
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    step();

    // Reset while a response is pending
    bus(1'b1, OFF_LED, 32'h0000_00FF);
    chk("pre_rst_led", 32'(led), 32'h00FF);
    rsp_ready = 1'b0;
    bus(1'b0, OFF_SW_STATE, 32'h0);
    chk("pre_rst_valid", 32'(rsp_valid), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_led", 32'(led), 32'h0);
    chk("midrst_irq", 32'(irq), 32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h1);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    rsp_ready = 1'b1;
    repeat (4) step();
    chk("post_rst_valid", 32'(rsp_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
